// File: rtl/uart_tx_port_if.sv
// Byte-write port and status bundle between the CPU-side write strobe and the UART transmitter.
// The master drives the write strobe and data; the slave (uart_tx_port) returns the serial line and FIFO status.
interface uart_tx_port_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          tx;
    logic          busy;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [CW-1:0] count;

    modport master (
        output wr_en, wr_data,
        input  tx, busy, full, empty, overflow, count
    );

    modport slave (
        input  wr_en, wr_data,
        output tx, busy, full, empty, overflow, count
    );
endinterface

// File: rtl/uart_tx_port.sv
// 8N1 UART transmitter fed by a small byte FIFO from the 0x800 output-port write strobe.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_port #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_port_if.slave  port
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, overflow_q;
    logic          push, pop, baud_tick;
    logic [7:0]    head;

    // Push is judged on the registered full flag, before any same-edge pop.
    assign push      = port.wr_en && !full_q;
    assign head      = mem[rd_ptr_q];
    assign baud_tick = (baud_q == '0);
    assign count_d   = count_q + CW'(push) - CW'(pop);

    // Next-state and frame-shaping logic
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_tick ? BAUD_RELOAD : (baud_q - BW'(1));
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = BAUD_RELOAD;
                if (!empty_q) begin
                    pop      = 1'b1;
                    shift_d  = head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                if (baud_tick) begin
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (baud_tick) begin
                    // Back-to-back frames: next start bit follows the stop bit directly.
                    if (!empty_q) begin
                        pop      = 1'b1;
                        shift_d  = head;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                        tx_d     = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transmitter state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= BAUD_RELOAD;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Byte FIFO with registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr_q] <= port.wr_data;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (port.wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == COUNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    assign port.tx       = tx_q;
    assign port.busy     = busy_q;
    assign port.full     = full_q;
    assign port.empty    = empty_q;
    assign port.overflow = overflow_q;
    assign port.count    = count_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: directed scenarios plus random writes against a queue-based line model.
// Build with +define+UART_TX_PARITY_EN to exercise the parity variant.
module tb_uart_tx_port;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
    localparam logic [15:0] A5_FRAME   = 16'h054A;
    localparam logic [15:0] C3_FRAME   = 16'h0478;
`else
    localparam int unsigned FRAME_BITS = 10;
    localparam logic [15:0] A5_FRAME   = 16'h034A;
    localparam logic [15:0] C3_FRAME   = 16'h0278;
`endif
    localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_tx_port_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_port #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .port  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: accepted bytes, and the expected line level for each future cycle.
    byte unsigned fifo_m[$];
    bit           line_m[$];
    bit           tx_m   = 1'b1;
    bit           busy_m = 1'b0;
    bit           ovf_m  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_bit(input bit b);
        for (int k = 0; k < int'(CPB); k++) line_m.push_back(b);
    endfunction

    function automatic void load_frame(input byte unsigned b);
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(b[i]);
`ifdef UART_TX_PARITY_EN
        push_bit(^b);
`endif
        push_bit(1'b1);
    endfunction

    function automatic void model_edge(input bit w, input byte unsigned d);
        bit was_full  = (fifo_m.size() == int'(DEPTH));
        bit was_empty = (fifo_m.size() == 0);
        if (line_m.size() == 0 && !was_empty) load_frame(fifo_m.pop_front());
        if (w) begin
            if (!was_full) fifo_m.push_back(d);
            else           ovf_m = 1'b1;
        end
        if (line_m.size() != 0) begin
            tx_m   = line_m.pop_front();
            busy_m = 1'b1;
        end else begin
            tx_m   = 1'b1;
            busy_m = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        fifo_m.delete();
        line_m.delete();
        tx_m   = 1'b1;
        busy_m = 1'b0;
        ovf_m  = 1'b0;
    endfunction

    task automatic check_outputs();
        chk("tx",       32'(bus.tx),       32'(tx_m));
        chk("busy",     32'(bus.busy),     32'(busy_m));
        chk("count",    32'(bus.count),    32'(fifo_m.size()));
        chk("full",     32'(bus.full),     32'(fifo_m.size() == int'(DEPTH)));
        chk("empty",    32'(bus.empty),    32'(fifo_m.size() == 0));
        chk("overflow", 32'(bus.overflow), 32'(ovf_m));
    endtask

    task automatic step(input bit w, input byte unsigned d);
        @(negedge clk);
        bus.wr_en   = w;
        bus.wr_data = d;
        @(posedge clk);
        model_edge(w, d);
        #1;
        check_outputs();
    endtask

    // Write one byte into an idle port, record busy length and tx at each bit start.
    task automatic send_one(input byte unsigned b, output int busy_len, output logic [15:0] samples);
        busy_len = 0;
        samples  = '0;
        step(1'b1, b);
        for (int j = 1; j <= int'(FRAME_CYC) + 16; j++) begin
            step(1'b0, 8'h00);
            if (bus.busy) busy_len++;
            if ((j - 1) % int'(CPB) == 0 && (j - 1) / int'(CPB) < int'(FRAME_BITS))
                samples[(j - 1) / int'(CPB)] = bus.tx;
        end
    endtask

    task automatic async_reset_check(input string tag);
        #2 reset = 1'b1;
        #1;
        chk({tag, "_tx"},    32'(bus.tx),       32'd1);
        chk({tag, "_busy"},  32'(bus.busy),     32'd0);
        chk({tag, "_count"}, 32'(bus.count),    32'd0);
        chk({tag, "_empty"}, 32'(bus.empty),    32'd1);
        chk({tag, "_ovf"},   32'(bus.overflow), 32'd0);
        model_reset();
        bus.wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int          blen;
        int          bcnt;
        logic [15:0] smp;

        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_full", 32'(bus.full), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        repeat (20) step(1'b0, 8'h00);

        // Single frames with known bit patterns
        send_one(8'hA5, blen, smp);
        chk("a5_busy_len", 32'(blen), 32'(FRAME_CYC));
        chk("a5_bits",     32'(smp),  32'(A5_FRAME));
        send_one(8'h07, blen, smp);
        chk("07_busy_len", 32'(blen),   32'(FRAME_CYC));
        chk("07_bit9",     32'(smp[9]), 32'd1);

        // Burst of five writes while idle: no gaps between frames
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
        chk("burst_full", 32'(bus.full),     32'd1);
        chk("burst_ovf",  32'(bus.overflow), 32'd0);
        bcnt = 0;
        for (int j = 0; j < int'(5 * FRAME_CYC) + 10; j++) begin
            step(1'b0, 8'h00);
            if (bus.busy) bcnt++;
        end
        chk("burst_busy_run", 32'(bcnt), 32'(5 * FRAME_CYC - 4));

        // Overflow while a frame is in flight
        step(1'b1, 8'h11);
        repeat (2) step(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h21 + i));
        chk("ovf_full", 32'(bus.full), 32'd1);
        step(1'b1, 8'hFF);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        repeat (5 * FRAME_CYC + 10) step(1'b0, 8'h00);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        chk("ovf_drained", 32'(bus.empty), 32'd1);

        // Reset during data bit 3, then a clean frame
        step(1'b1, 8'h5A);
        repeat (18) step(1'b0, 8'h00);
        async_reset_check("midframe_rst");
        send_one(8'h3C, blen, smp);
        chk("3c_busy_len", 32'(blen), 32'(FRAME_CYC));
        chk("3c_bits",     32'(smp),  32'(C3_FRAME));

        // Random writes against the model
        for (int j = 0; j < 800; j++) step($urandom_range(0, 11) == 0, 8'($urandom));
        repeat (DEPTH * FRAME_CYC + FRAME_CYC + 10) step(1'b0, 8'h00);
        chk("rand_idle_busy", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
